pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
//   Generic parametrised inter-stage pipeline register for the pipelined CPU (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Replaces fixed free-running stage registers with a valid/ready stage:
//   - 2-entry skid buffer, so backpressure does not need a combinational ready path through the stage.
//   - Synchronous flush for branch/jump kill.
//   - Control-field zeroing so that bubbles behave as NOPs.
//   - Saturating stall-cycle counter for performance analysis.
// PARAMETERS
//   DATA_W   270  width of datapath payload (pc, rs1, rs2, imm, rd, funct bits); not cleared on flush
//   CTRL_W   10   width of control payload (RegWrite, MemWrite, Branch, Jump, ...); zeroed on flush/bubble
//   SKID_EN  1    1: 2-entry skid, registered in_ready; 0: single entry, in_ready = ~m_valid | out_ready
//   CNT_W    32   width of stall counter
// PORTS
//   clk        in   1       rising-edge clock
//   reset_n    in   1       asynchronous active-low reset
//   flush      in   1       synchronous kill of all held entries (branch mispredict / jump)
//   in_valid   in   1       upstream entry valid
//   in_ready   out  1       stage can accept; transfer when in_valid & in_ready
//   in_data    in   DATA_W  upstream datapath payload
//   in_ctrl    in   CTRL_W  upstream control payload
//   out_valid  out  1       head entry valid
//   out_ready  in   1       downstream accepts; transfer when out_valid & out_ready
//   out_data   out  DATA_W  head datapath payload
//   out_ctrl   out  CTRL_W  head control payload, forced 0 when out_valid = 0
//   occupancy  out  2       number of held entries (0..2)
//   stat_clr   in   1       synchronous clear of stall_cnt
//   stall_cnt  out  CNT_W   saturating count of cycles with out_valid & ~out_ready
// BEHAVIOUR
//   - Storage: main entry M (m_valid, m_data, m_ctrl) drives out_*; skid entry S used only when SKID_EN = 1.
//   - Reset (reset_n low, async):
//     - m_valid = s_valid = 0; all data/ctrl regs = 0; stall_cnt = 0; occupancy = 0; out_ctrl = 0.
//     - in_ready = 1 with SKID_EN = 1; in_ready = out_ready with SKID_EN = 0.
//     - No transfer is captured while reset_n is low.
//   - Latency: an accepted entry appears on out_* the cycle after the in transfer (1 cycle).
//   - States (SKID_EN = 1), with in_fire = in_valid & in_ready, out_fire = out_valid & out_ready:
//     - EMPTY (M-, S-):
//       - in_fire -> ONE, M <= in.
//     - ONE (M+, S-):
//       - in_fire & out_fire -> ONE, M <= in.
//       - in_fire & ~out_fire -> FULL, S <= in.
//       - ~in_fire & out_fire -> EMPTY.
//       - Otherwise hold.
//     - FULL (M+, S+): in_ready = 0.
//       - out_fire -> ONE, M <= S.
//       - Otherwise hold.
//   - in_ready = ~s_valid. It is a pure flop output and has no combinational path from out_ready.
//   - SKID_EN = 0: only EMPTY/ONE exist; in_ready = ~m_valid | out_ready; in_fire & out_fire replaces M.
//   - Ordering: strict FIFO; an entry is never duplicated or dropped except by flush.
//   - Flush (highest priority, sampled on clk edge):
//     - m_valid, s_valid <= 0 and m_ctrl, s_ctrl <= 0; data regs keep their value.
//     - An in_fire in the flush cycle is discarded; an out_fire in the same cycle is still a valid transfer.
//     - out_valid = 0 from the next cycle.
//   - out_ctrl = m_valid ? m_ctrl : 0, so that stalls and bubbles never assert RegWrite/MemWrite downstream.
//   - occupancy = m_valid + s_valid.
//   - Stable-hold rule: while out_valid & ~out_ready, out_data and out_ctrl must not change unless flush.
//   - stall_cnt:
//     - +1 each cycle out_valid & ~out_ready; saturates at 2^CNT_W-1 (no wrap).
//     - stat_clr sets it to 0 and wins over increment in the same cycle.
//   - Reset mid-operation discards all held entries immediately (async); no partial transfer completes.
// TESTING
//   1. Streaming: in_valid = 1 and out_ready = 1 for 8 cycles with data 1..8
//      -> out_data 1..8 each one cycle later; occupancy = 1; stall_cnt = 0.
//   2. Backpressure: out_ready = 0 while pushing A, B, C
//      -> A and B accepted; in_ready = 0 after B (occupancy = 2); C held upstream.
//      -> Then out_ready = 1: A, B, C appear in order; no loss or duplication.
//   3. Flush in FULL with in_fire pending
//      -> next cycle out_valid = 0, occupancy = 0, out_ctrl = 0; pending input not seen downstream.
//   4. Stall counting: hold out_valid & ~out_ready for 5 cycles -> stall_cnt = 5.
//      -> stat_clr with a stall in the same cycle -> stall_cnt = 0.
//      -> CNT_W = 4 with 20 stalls -> stall_cnt = 15.
//   5. Async reset while occupancy = 2: drop reset_n mid-cycle
//      -> out_valid = 0 and out_ctrl = 0 immediately; after release, first input accepted normally.
//   6. SKID_EN = 0: in_ready tracks out_ready while M is valid.
//      -> Simultaneous in/out fire replaces M with 1-cycle latency and occupancy never exceeds 1.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry
// skid buffer, synchronous flush, bubble control zeroing and a saturating
// stall-cycle counter.
module pipe_stage_skid #(
    parameter int DATA_W  = 270,
    parameter int CTRL_W  = 10,
    parameter bit SKID_EN = 1'b1,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Main entry M drives the outputs; skid entry S catches the one extra
    // word that can arrive while the downstream is refusing M.
    logic              m_valid, s_valid;
    logic [DATA_W-1:0] m_data,  s_data;
    logic [CTRL_W-1:0] m_ctrl,  s_ctrl;
    logic              in_fire, out_fire;

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_valid ? m_ctrl : '0;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = m_valid & out_ready;

    generate
        if (SKID_EN) begin : g_rdy
            // Ready comes straight from the skid flop: no path from out_ready.
            assign in_ready = ~s_valid;
        end else begin : g_rdy
            // Single entry: can refill in the same cycle M drains. While in
            // reset M is empty but nothing may be captured, so only
            // out_ready is passed through.
            assign in_ready = (~m_valid & reset_n) | out_ready;
        end
    endgenerate

    // Main entry: load from input when empty or draining, refill from skid,
    // otherwise hold; flush kills validity and control but leaves data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ctrl  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_ctrl  <= '0;
        end else if (s_valid) begin
            if (out_fire) begin
                m_data <= s_data;
                m_ctrl <= s_ctrl;
            end
        end else if (in_fire && (!m_valid || out_fire)) begin
            m_valid <= 1'b1;
            m_data  <= in_data;
            m_ctrl  <= in_ctrl;
        end else if (out_fire) begin
            m_valid <= 1'b0;
            m_ctrl  <= '0;
        end
    end

    // Skid entry: captures the input only when M is held by backpressure,
    // and empties as soon as it has been moved into M.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_valid <= 1'b0;
            s_data  <= '0;
            s_ctrl  <= '0;
        end else if (flush) begin
            s_valid <= 1'b0;
            s_ctrl  <= '0;
        end else if (s_valid) begin
            if (out_fire) begin
                s_valid <= 1'b0;
                s_ctrl  <= '0;
            end
        end else if (SKID_EN && in_fire && m_valid && !out_fire) begin
            s_valid <= 1'b1;
            s_data  <= in_data;
            s_ctrl  <= in_ctrl;
        end
    end

    // Stall counter: counts cycles the head is offered but refused,
    // sticks at all-ones, and a clear request beats the increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stat_clr) begin
            stall_cnt <= '0;
        end else if (m_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
